// File: rtl/signed_stream_acc_pkg.sv
// Shared types and constants for the signed stream accumulator.
// Optional feature macro used by this slice: SATURATE_EN.
package signed_stream_acc_pkg;

    // state | meaning
    // ACC   | collecting operands, up side open
    // HOLD  | frame result presented, waiting for consumer
    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } acc_state_t;

    // Largest signed value representable in w bits.
    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Most negative signed value representable in w bits.
    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/signed_stream_accumulator_if.sv
// Operand (up) and result (down) valid/ready channels of the accumulator.
interface signed_stream_accumulator_if #(
    parameter int W = 4
);
    logic         up_valid;
    logic         up_ready;
    logic [W-1:0] up_data;
    logic         down_valid;
    logic         down_ready;
    logic [W-1:0] down_sum;
    logic         down_overflow;

    modport master (
        output up_valid, up_data, down_ready,
        input  up_ready, down_valid, down_sum, down_overflow
    );

    modport slave (
        input  up_valid, up_data, down_ready,
        output up_ready, down_valid, down_sum, down_overflow
    );
endinterface

// File: rtl/signed_add_ovf_step.sv
// One W-bit two's-complement add step with signed overflow detection.
// With SATURATE_EN defined, also provides the clamped sum.
module signed_add_ovf_step
    import signed_stream_acc_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
`ifdef SATURATE_EN
    ,
    output logic [W-1:0] sat_sum
`endif
);

    // Wrapped sum; overflow when both operands share a sign the result lacks.
    always_comb begin
        sum = a + b;
        ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
    end

`ifdef SATURATE_EN
    // Clamp toward the sign of the incoming operand on overflow.
    always_comb begin
        sat_sum = sum;
        if (ovf) begin
            sat_sum = b[W-1] ? W'(sat_min(W)) : W'(sat_max(W));
        end
    end
`endif

endmodule

// File: rtl/signed_stream_accumulator.sv
// Folds each group of N_OPS signed operands into one frame sum with a sticky
// overflow flag. Define SATURATE_EN to clamp the running sum on overflow
// instead of wrapping.
//
// state | meaning
// ACC   | up_ready=1, accepting operands into acc
// HOLD  | down_valid=1, acc/ovf_sticky presented and frozen
module signed_stream_accumulator
    import signed_stream_acc_pkg::*;
#(
    parameter int W     = 4,
    parameter int N_OPS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    signed_stream_accumulator_if.slave  bus
);

    localparam int CNT_W = (N_OPS > 1) ? $clog2(N_OPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_OPS - 1);

    acc_state_t       state, state_nxt;
    logic [W-1:0]     acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ovf_sticky, ovf_nxt;

    logic [W-1:0]     step_sum;
    logic             step_ovf;
    logic [W-1:0]     step_acc;

`ifdef SATURATE_EN
    logic [W-1:0]     step_sat;

    signed_add_ovf_step #(.W(W)) u_step (
        .a       (acc),
        .b       (bus.up_data),
        .sum     (step_sum),
        .ovf     (step_ovf),
        .sat_sum (step_sat)
    );

    assign step_acc = step_sat;
`else
    signed_add_ovf_step #(.W(W)) u_step (
        .a   (acc),
        .b   (bus.up_data),
        .sum (step_sum),
        .ovf (step_ovf)
    );

    assign step_acc = step_sum;
`endif

    // Outputs come straight from state decode and registers only.
    assign bus.up_ready      = (state == ACC);
    assign bus.down_valid    = (state == HOLD);
    assign bus.down_sum      = acc;
    assign bus.down_overflow = ovf_sticky;

    // Register update; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACC;
            acc        <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            cnt        <= cnt_nxt;
            ovf_sticky <= ovf_nxt;
        end
    end

    // Next-state: accumulate on up handshakes, release frame on down handshake.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf_sticky;
        case (state)
            ACC: begin
                if (bus.up_valid) begin
                    acc_nxt = step_acc;
                    ovf_nxt = ovf_sticky | step_ovf;
                    if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = HOLD;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (bus.down_ready) begin
                    state_nxt = ACC;
                    acc_nxt   = '0;
                    ovf_nxt   = 1'b0;
                end
            end
            default: state_nxt = ACC;
        endcase
    end

endmodule

// File: tb/tb_signed_stream_accumulator.sv
module tb_signed_stream_accumulator;
    localparam int W     = 4;
    localparam int N_OPS = 4;
    localparam int MAXV  = (1 << (W - 1)) - 1;
    localparam int MINV  = -(1 << (W - 1));

    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_pass  = 0;

    signed_stream_accumulator_if #(.W(W)) bus_if ();

    signed_stream_accumulator #(.W(W), .N_OPS(N_OPS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: exact integer arithmetic with range test per step.
    task automatic model_frame(input logic [W-1:0] ops[N_OPS],
                               output logic [W-1:0] sum, output logic ovf);
        int a;
        int x;
        int e;
        a   = 0;
        ovf = 1'b0;
        for (int i = 0; i < N_OPS; i++) begin
            x = int'($signed(ops[i]));
            e = a + x;
            if (e > MAXV || e < MINV) begin
                ovf = 1'b1;
`ifdef SATURATE_EN
                a = (x >= 0) ? MAXV : MINV;
`else
                a = (e > MAXV) ? e - (1 << W) : e + (1 << W);
`endif
            end else begin
                a = e;
            end
        end
        sum = W'(a);
    endtask

    // Push operands; optional idle gaps carry junk data without up_valid.
    task automatic send_ops(input logic [W-1:0] ops[N_OPS], input int n, input bit gaps);
        bit ok;
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                bus_if.up_valid = 1'b0;
                bus_if.up_data  = W'($urandom);
                @(posedge clk);
                #1;
            end
            bus_if.up_valid = 1'b1;
            bus_if.up_data  = ops[i];
            ok = 1'b0;
            for (int t = 0; t < 50 && !ok; t++) begin
                @(negedge clk);
                if (bus_if.up_ready) ok = 1'b1;
            end
            if (!ok) begin
                check("up_ready_timeout", 32'd0, 32'd1);
                bus_if.up_valid = 1'b0;
                return;
            end
            if (i == N_OPS - 1) check("no_early_valid", bus_if.down_valid, 1'b0);
            @(posedge clk);
            #1;
        end
        bus_if.up_valid = 1'b0;
    endtask

    task automatic do_frame(input logic [W-1:0] ops[N_OPS], input logic [W-1:0] exp_sum,
                            input logic exp_ovf, input int stall);
        send_ops(ops, N_OPS, 1'b1);
        check("latency_down_valid", bus_if.down_valid, 1'b1);
        check("hold_up_ready", bus_if.up_ready, 1'b0);
        check("down_sum", bus_if.down_sum, exp_sum);
        check("down_overflow", bus_if.down_overflow, exp_ovf);
        bus_if.down_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            bus_if.up_valid = 1'($urandom);
            bus_if.up_data  = W'($urandom);
            @(posedge clk);
            #1;
            check("stall_valid", bus_if.down_valid, 1'b1);
            check("stall_up_ready", bus_if.up_ready, 1'b0);
            check("stall_sum", bus_if.down_sum, exp_sum);
            check("stall_ovf", bus_if.down_overflow, exp_ovf);
        end
        bus_if.up_valid   = 1'b0;
        bus_if.down_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.down_ready = 1'b0;
        check("post_down_valid", bus_if.down_valid, 1'b0);
        check("post_up_ready", bus_if.up_ready, 1'b1);
    endtask

    logic [W-1:0] ops[N_OPS];
    logic [W-1:0] m_sum;
    logic         m_ovf;

    initial begin
        rst               = 1'b1;
        bus_if.up_valid   = 1'b0;
        bus_if.up_data    = '0;
        bus_if.down_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_up_ready", bus_if.up_ready, 1'b1);
        check("rst_down_valid", bus_if.down_valid, 1'b0);
        check("rst_down_sum", bus_if.down_sum, 4'd0);
        check("rst_down_ovf", bus_if.down_overflow, 1'b0);
        rst = 1'b0;

        ops = '{4'd1, 4'd2, 4'd3, 4'hF};
        do_frame(ops, 4'd5, 1'b0, 0);

        ops = '{4'd7, 4'd1, 4'd0, 4'd0};
`ifdef SATURATE_EN
        do_frame(ops, 4'd7, 1'b1, 0);
`else
        do_frame(ops, 4'b1000, 1'b1, 0);
`endif

        ops = '{4'd4, 4'd4, 4'hC, 4'd0};
`ifdef SATURATE_EN
        do_frame(ops, 4'd3, 1'b1, 1);
`else
        do_frame(ops, 4'd4, 1'b1, 1);
`endif

        ops = '{4'h8, 4'hF, 4'd0, 4'd0};
`ifdef SATURATE_EN
        do_frame(ops, 4'h8, 1'b1, 3);
`else
        do_frame(ops, 4'd7, 1'b1, 3);
`endif

        ops = '{4'd1, 4'd1, 4'd1, 4'd1};
        do_frame(ops, 4'd4, 1'b0, 0);

        // Abort mid-frame; reset coincides with a would-be handshake.
        ops = '{4'd5, 4'd3, 4'd0, 4'd0};
        send_ops(ops, 2, 1'b0);
        rst             = 1'b1;
        bus_if.up_valid = 1'b1;
        bus_if.up_data  = 4'd7;
        @(posedge clk);
        #1;
        rst             = 1'b0;
        bus_if.up_valid = 1'b0;
        check("abort_sum", bus_if.down_sum, 4'd0);
        check("abort_ready", bus_if.up_ready, 1'b1);
        ops = '{4'd2, 4'd2, 4'd2, 4'd2};
`ifdef SATURATE_EN
        do_frame(ops, 4'd7, 1'b1, 0);
`else
        do_frame(ops, 4'b1000, 1'b1, 0);
`endif

        // Reset while a result is pending drops it.
        ops = '{4'd7, 4'd7, 4'd0, 4'd0};
        send_ops(ops, N_OPS, 1'b0);
        check("pre_rst_hold", bus_if.down_valid, 1'b1);
        rst               = 1'b1;
        bus_if.down_ready = 1'b1;
        @(posedge clk);
        #1;
        rst               = 1'b0;
        bus_if.down_ready = 1'b0;
        check("rst_hold_valid", bus_if.down_valid, 1'b0);
        check("rst_hold_sum", bus_if.down_sum, 4'd0);
        check("rst_hold_ovf", bus_if.down_overflow, 1'b0);

        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < N_OPS; i++) ops[i] = W'($urandom);
            model_frame(ops, m_sum, m_ovf);
            do_frame(ops, m_sum, m_ovf, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
